// File: rtl/noun_loader_if.sv
// Byte-stream and memory-write bus between the noun loader and its neighbours.
// The master modport is the loader side; slave is the host/memory side.
interface noun_loader_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_ready;
  logic                  mem_execute;
  logic [1:0]            mem_func;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    input  in_data,
    input  in_valid,
    input  mem_ready,
    output in_ready,
    output mem_execute,
    output mem_func,
    output address,
    output write_data
  );

  modport slave (
    output in_data,
    output in_valid,
    output mem_ready,
    input  in_ready,
    input  mem_execute,
    input  mem_func,
    input  address,
    input  write_data
  );
endinterface

// File: rtl/noun_loader.sv
// Streams a noun image byte-by-byte into memory, packing little-endian words
// and writing them to consecutive addresses, then pulses trav_start.
module noun_loader #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 64,
  parameter logic [1:0]  WRITE_FUNC = 2'b10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  noun_loader_if.master         bus,
  output logic                  o_bus_owner,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_trav_start,
  output logic [7:0]            o_checksum
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned IdxW  = (Bytes > 1) ? $clog2(Bytes) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Bytes - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StIssue,
    StWaitAck,
    StDone
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_remaining;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IdxW-1:0]       r_byte_idx;
  logic [7:0]            r_checksum;
  logic                  r_wait_first;

  logic w_last_byte;
  logic w_accept;
  logic w_exec;
  logic w_ack;

  assign w_last_byte = (r_byte_idx == LastIdx);
  assign w_accept    = (r_state == StCollect) && bus.in_valid;
  assign w_exec      = (r_state == StIssue) && bus.mem_ready;
  // The cycle right after the strobe never counts as the write acknowledge.
  assign w_ack       = (r_state == StWaitAck) && !r_wait_first && bus.mem_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_load_start) begin
          w_state_next = (i_word_count == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (w_accept && w_last_byte) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        if (bus.mem_ready) begin
          w_state_next = StWaitAck;
        end
      end
      StWaitAck: begin
        if (w_ack) begin
          w_state_next = (r_remaining == ADDR_WIDTH'(1)) ? StDone : StCollect;
        end
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr       <= '0;
      r_remaining  <= '0;
      r_data       <= '0;
      r_byte_idx   <= '0;
      r_checksum   <= '0;
      r_wait_first <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_load_start) begin
            r_addr      <= i_base_addr;
            r_remaining <= i_word_count;
            r_data      <= '0;
            r_byte_idx  <= '0;
            r_checksum  <= '0;
          end
        end
        StCollect: begin
          if (w_accept) begin
            r_data[8*r_byte_idx +: 8] <= bus.in_data;
            r_checksum                <= r_checksum ^ bus.in_data;
            r_byte_idx                <= w_last_byte ? '0 : r_byte_idx + IdxW'(1);
          end
        end
        StIssue: begin
          if (w_exec) begin
            r_wait_first <= 1'b1;
          end
        end
        StWaitAck: begin
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (w_ack) begin
            r_remaining <= r_remaining - ADDR_WIDTH'(1);
            r_addr      <= r_addr + ADDR_WIDTH'(1);
            if (r_remaining != ADDR_WIDTH'(1)) begin
              r_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready    = (r_state == StCollect);
    bus.mem_execute = w_exec;
    bus.mem_func    = w_exec ? WRITE_FUNC : 2'b00;
    bus.address     = r_addr;
    bus.write_data  = r_data;
    o_busy          = (r_state == StCollect) || (r_state == StIssue) || (r_state == StWaitAck);
    o_bus_owner     = o_busy;
    o_done          = (r_state == StDone);
    o_trav_start    = (r_state == StDone);
    o_checksum      = r_checksum;
  end

endmodule

// File: tb/tb_noun_loader.sv
// Directed self-checking bench for noun_loader: abort, multi-word, empty,
// address wrap, stalls on both sides and ignored restart.
module tb_noun_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_start;
  logic [9:0] base_addr;
  logic [9:0] word_count;
  logic       bus_owner, busy, done, trav_start;
  logic [7:0] checksum;

  int n_checks = 0;
  int n_fail   = 0;
  int exec_count = 0;
  int exec_before;
  logic mon_prev = 1'b0;

  noun_loader_if #(.ADDR_WIDTH(10), .DATA_WIDTH(64)) bus ();

  noun_loader #(
    .ADDR_WIDTH(10),
    .DATA_WIDTH(64),
    .WRITE_FUNC(2'b10)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_load_start(load_start),
    .i_base_addr (base_addr),
    .i_word_count(word_count),
    .bus         (bus),
    .o_bus_owner (bus_owner),
    .o_busy      (busy),
    .o_done      (done),
    .o_trav_start(trav_start),
    .o_checksum  (checksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Strobes must be single-cycle and never back to back.
  always @(negedge clk) begin
    if (bus.mem_execute === 1'b1) begin
      exec_count++;
      n_checks++;
      assert (mon_prev !== 1'b1) else begin
        n_fail++;
        $error("FAIL exec_back_to_back: observed 1 expected 0");
      end
    end
    mon_prev = bus.mem_execute;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [9:0] base, input logic [9:0] cnt);
    base_addr  = base;
    word_count = cnt;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    base_addr  = ~base;
    word_count = 10'd0;
    if (cnt != 10'd0) begin
      chk("load_busy", 64'(busy), 64'd1);
      chk("load_owner", 64'(bus_owner), 64'd1);
      chk("load_addr", 64'(bus.address), 64'(base));
      chk("load_cksum", 64'(checksum), 64'd0);
      chk("load_in_ready", 64'(bus.in_ready), 64'd1);
    end
  endtask

  task automatic feed_word(input logic [63:0] word, input bit gappy);
    for (int k = 0; k < 8; k++) begin
      if (gappy) begin
        bus.in_valid = 1'b0;
        step();
        chk("gap_in_ready", 64'(bus.in_ready), 64'd1);
      end
      chk("feed_in_ready", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.in_data  = word[8*k +: 8];
      step();
    end
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic issue(input logic [9:0] exp_addr, input logic [63:0] exp_word,
                       input int delay);
    bus.mem_ready = 1'b0;
    for (int d = 0; d < delay; d++) begin
      #1;
      chk("stall_exec", 64'(bus.mem_execute), 64'd0);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
      step();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("issue_exec", 64'(bus.mem_execute), 64'd1);
    chk("issue_func", 64'(bus.mem_func), 64'd2);
    chk("issue_addr", 64'(bus.address), 64'(exp_addr));
    chk("issue_data", bus.write_data, exp_word);
    step();
    chk("wait1_exec", 64'(bus.mem_execute), 64'd0);
    chk("wait1_func", 64'(bus.mem_func), 64'd0);
    step();
    chk("wait2_exec", 64'(bus.mem_execute), 64'd0);
    chk("wait2_addr", 64'(bus.address), 64'(exp_addr));
    chk("wait2_data", bus.write_data, exp_word);
    step();
    bus.mem_ready = 1'b0;
  endtask

  task automatic expect_done(input logic [7:0] exp_cksum);
    chk("done", 64'(done), 64'd1);
    chk("trav_start", 64'(trav_start), 64'd1);
    chk("done_busy", 64'(busy), 64'd0);
    chk("done_owner", 64'(bus_owner), 64'd0);
    chk("done_cksum", 64'(checksum), 64'(exp_cksum));
    step();
    chk("done_drop", 64'(done), 64'd0);
    chk("trav_drop", 64'(trav_start), 64'd0);
    chk("cksum_hold", 64'(checksum), 64'(exp_cksum));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    load_start = 1'b0;
    base_addr = '0;
    word_count = '0;
    bus.in_data = '0;
    bus.in_valid = 1'b0;
    bus.mem_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // Abort mid-collect after three bytes.
    do_load(10'd3, 10'd1);
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hC0 + 8'(k);
      step();
    end
    bus.in_valid = 1'b0;
    chk("pre_rst_cksum", 64'(checksum), 64'h00C3);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_exec", 64'(bus.mem_execute), 64'd0);
    chk("rst_func", 64'(bus.mem_func), 64'd0);
    chk("rst_addr", 64'(bus.address), 64'd0);
    chk("rst_data", bus.write_data, 64'd0);
    chk("rst_owner", 64'(bus_owner), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_trav", 64'(trav_start), 64'd0);
    chk("rst_cksum", 64'(checksum), 64'd0);
    chk("rst_no_exec", 64'(exec_count), 64'd0);

    // Two words from address 5.
    do_load(10'd5, 10'd2);
    feed_word(64'h0807060504030201, 1'b0);
    issue(10'd5, 64'h0807060504030201, 2);
    chk("w2_collect", 64'(bus.in_ready), 64'd1);
    chk("w2_data_clr", bus.write_data, 64'd0);
    chk("w2_addr", 64'(bus.address), 64'd6);
    feed_word(64'h100F0E0D0C0B0A09, 1'b0);
    issue(10'd6, 64'h100F0E0D0C0B0A09, 2);
    expect_done(8'h10);

    // Empty load.
    exec_before = exec_count;
    do_load(10'd9, 10'd0);
    chk("empty_in_ready", 64'(bus.in_ready), 64'd0);
    expect_done(8'h00);
    chk("empty_no_exec", 64'(exec_count), 64'(exec_before));

    // Address wrap.
    do_load(10'd1023, 10'd2);
    feed_word(64'h1817161514131211, 1'b0);
    issue(10'd1023, 64'h1817161514131211, 0);
    feed_word(64'h201F1E1D1C1B1A19, 1'b0);
    issue(10'd0, 64'h201F1E1D1C1B1A19, 1);
    expect_done(8'h30);

    // Gappy input and long memory stall.
    do_load(10'd7, 10'd1);
    feed_word(64'hA8A7A6A5A4A3A2A1, 1'b1);
    issue(10'd7, 64'hA8A7A6A5A4A3A2A1, 10);
    expect_done(8'h08);

    // Restart while busy is ignored.
    do_load(10'd20, 10'd1);
    base_addr  = 10'd100;
    word_count = 10'd5;
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    chk("restart_addr", 64'(bus.address), 64'd20);
    chk("restart_busy", 64'(busy), 64'd1);
    feed_word(64'h00000000000000FF, 1'b0);
    issue(10'd20, 64'h00000000000000FF, 0);
    expect_done(8'hFF);
    step();
    chk("final_idle_busy", 64'(busy), 64'd0);
    chk("total_exec", 64'(exec_count), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/noun_loader.md
Name: noun_loader

Overview:
- Upstream stage to the memory unit. Streams a pre-encoded noun image, as bytes from a host link, into memory before the traversal unit runs.
- Packs bytes little-endian into memory words and writes them to consecutive addresses through the standard memory request interface (func/execute/address/write_data, is_ready).
- When the image is loaded, pulses trav_start. This replaces the testbench-only hex preload with a synthesizable path.

Parameters:
- ADDR_WIDTH, 10, memory address width; must equal `memory_addr_width.
- DATA_WIDTH, 64, memory word width; must equal `memory_data_width and be a multiple of 8.
- WRITE_FUNC, 2'b10, mem_func encoding for a memory write.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- load_start  in  1  one-cycle pulse that begins a load
- base_addr  in  ADDR_WIDTH  first word address, sampled on load_start
- word_count  in  ADDR_WIDTH  number of words to write, sampled on load_start
- in_data  in  8  byte stream data
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- mem_ready  in  1  memory is_ready
- mem_execute  out  1  one-cycle memory request strobe
- mem_func  out  2  WRITE_FUNC while a request is driven, else 2'b00
- address  out  ADDR_WIDTH  write address
- write_data  out  DATA_WIDTH  packed word
- bus_owner  out  1  high while the loader owns the memory bus (mux select)
- busy  out  1  load in progress
- done  out  1  one-cycle pulse when the load completes
- trav_start  out  1  one-cycle pulse, same cycle as done
- checksum  out  8  XOR of all bytes accepted in the current load

Behaviour:
- Reset (rst=1 at a clk edge):
  - state IDLE.
  - All outputs 0: in_ready, mem_execute, mem_func, address, write_data, bus_owner, busy, done, trav_start, checksum.
  - Internal byte index and word counter cleared.
  - Reset mid-load aborts immediately. No further requests are issued. A request already strobed is not retracted.
- States: IDLE, COLLECT, ISSUE, WAIT_ACK, DONE.
- IDLE:
  - On load_start, latch base_addr into address, latch word_count, clear checksum, set busy=1 and bus_owner=1.
  - If word_count==0, go to DONE; else go to COLLECT.
  - load_start is ignored in every state except IDLE.
- COLLECT:
  - in_ready=1.
  - Each accepted byte k (k=0..DATA_WIDTH/8-1) goes to write_data[8k+7:8k], and checksum ^= byte.
  - After the last byte of the word is accepted, in_ready drops the next cycle and the state moves to ISSUE.
  - in_valid gaps simply stall. There is no timeout.
- ISSUE:
  - Wait for mem_ready=1. In that cycle assert mem_execute=1 and mem_func=WRITE_FUNC for exactly one cycle, with address and write_data stable.
  - Then go to WAIT_ACK.
- WAIT_ACK:
  - mem_ready is ignored on the first cycle after the strobe.
  - The write completes on the first subsequent cycle with mem_ready=1.
  - On completion, decrement the remaining count and increment address modulo 2^ADDR_WIDTH (wrap from all-ones to 0 is legal and silent).
  - If remaining==0, go to DONE; else clear write_data and go to COLLECT.
  - address and write_data hold until the transition out of WAIT_ACK.
- DONE:
  - One cycle: done=1, trav_start=1, busy=0, bus_owner=0.
  - Next state IDLE. checksum holds until the next load_start.
- Request rule: at most one outstanding memory request. mem_execute is never high on two consecutive cycles.
- Latency: an uninterrupted word costs DATA_WIDTH/8 cycles (COLLECT) + 1 (ISSUE, if ready) + at least 2 (WAIT_ACK).

Test Plan:
1. Reset with rst=1 for 2 cycles mid-COLLECT (3 bytes accepted) -> all outputs 0 and state IDLE on the cycle after reset. The next load_start works normally.
2. base_addr=5, word_count=2, bytes 0x01..0x10 with in_valid held high, memory ready after 2 cycles -> writes 0x0807060504030201 to address 5, then 0x100F0E0D0C0B0A09 to address 6. done and trav_start each pulse once. checksum=0x10.
3. word_count=0 -> done and trav_start pulse 1 cycle after load_start. No mem_execute. in_ready stays 0.
4. base_addr=1023 (ADDR_WIDTH=10), word_count=2 -> writes land at 1023 then 0.
5. in_valid toggling 1/0 and mem_ready held low 10 cycles in ISSUE -> no byte is lost or duplicated. mem_execute stays low until mem_ready rises, then is exactly one cycle wide.
6. load_start pulsed again while busy -> ignored. base_addr, word_count and the write sequence are unchanged.
